// File: rtl/clock_op_sequencer_pkg.sv
`default_nettype none
// clock_op_sequencer_pkg: op encodings, FSM states and request arbitration helpers (rev 1.0)
package clock_op_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_MADD  = 2'b10;
  localparam logic [1:0] OP_STO0  = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b11;

  localparam int unsigned REQ_MADD  = 0;
  localparam int unsigned REQ_STO0  = 1;
  localparam int unsigned REQ_RESET = 2;

  // Fixed priority: clear-time beats seconds-to-zero beats minute-add.
  function automatic logic [1:0] arbitrate(input logic [2:0] req);
    logic [1:0] op;
    op = OP_NONE;
    if (req[REQ_RESET])     op = OP_RESET;
    else if (req[REQ_STO0]) op = OP_STO0;
    else if (req[REQ_MADD]) op = OP_MADD;
    return op;
  endfunction

  // A completed clear-time makes any queued sto0/madd request redundant.
  function automatic logic [2:0] clear_mask(input logic [1:0] op);
    logic [2:0] mask;
    mask = 3'b000;
    case (op)
      OP_RESET: mask = 3'b111;
      OP_STO0:  mask = 3'b010;
      OP_MADD:  mask = 3'b001;
      default:  mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_op_sequencer_btn_debounce.sv
`default_nettype none
// clock_op_sequencer_btn_debounce: 2-FF synchroniser, stability debounce and rising-edge pulse (rev 1.0)
module clock_op_sequencer_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // The counter only runs while the synchronised input disagrees with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_d;

endmodule
`default_nettype wire

// File: rtl/clock_op_sequencer.sv
`default_nettype none
// clock_op_sequencer: debounced button requests arbitrated into one-at-a-time counter ops,
// plus the seconds-tick prescaler that re-phases on seconds-zero / clear (rev 1.0)
module clock_op_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TICK_DIV        = 50000000,
  parameter int unsigned HOLDOFF_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_madd,
  input  logic       btn_sto0,
  input  logic       btn_reset,
  input  logic       op_ack,
  output logic       op_valid,
  output logic [1:0] op_code,
  output logic       sec_tick,
  output logic       busy
);

  import clock_op_sequencer_pkg::*;

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);

  logic [2:0]    btn_raw;
  logic [2:0]    rise;
  logic [2:0]    pending;
  logic [2:0]    pending_nxt;
  logic [2:0]    clear;
  state_t        state;
  state_t        state_nxt;
  logic          op_valid_nxt;
  logic [1:0]    op_code_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_nxt;
  logic [PW-1:0] pre_cnt;
  logic          restart;

  assign btn_raw = {btn_reset, btn_sto0, btn_madd};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_btn
      clock_op_sequencer_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_raw[i]),
        .rise (rise[i])
      );
    end
  endgenerate

  always_comb begin
    state_nxt    = state;
    op_valid_nxt = op_valid;
    op_code_nxt  = op_code;
    hold_cnt_nxt = hold_cnt;
    clear        = 3'b000;
    case (state)
      S_IDLE: begin
        if (|pending) begin
          state_nxt    = S_ISSUE;
          op_valid_nxt = 1'b1;
          op_code_nxt  = arbitrate(pending);
        end
      end
      S_ISSUE: begin
        if (op_ack) begin
          clear        = clear_mask(op_code);
          state_nxt    = S_HOLDOFF;
          op_valid_nxt = 1'b0;
          op_code_nxt  = OP_NONE;
          hold_cnt_nxt = '0;
        end
      end
      S_HOLDOFF: begin
        if (hold_cnt == HW'(HOLDOFF_CYCLES - 1)) begin
          state_nxt    = S_IDLE;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        op_valid_nxt = 1'b0;
        op_code_nxt  = OP_NONE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Clear before set so a press landing on its own ack cycle is kept.
  assign pending_nxt = (pending & ~clear) | rise;

  assign restart  = (state == S_ISSUE) && op_ack && ((op_code == OP_STO0) || (op_code == OP_RESET));
  assign sec_tick = (pre_cnt == PW'(TICK_DIV - 1)) && !restart;
  assign busy     = (|pending) || (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_valid <= 1'b0;
      op_code  <= OP_NONE;
      hold_cnt <= '0;
      pending  <= 3'b000;
      pre_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      op_valid <= op_valid_nxt;
      op_code  <= op_code_nxt;
      hold_cnt <= hold_cnt_nxt;
      pending  <= pending_nxt;
      if (restart || (pre_cnt == PW'(TICK_DIV - 1))) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_op_sequencer.sv
`default_nettype none
// tb_clock_op_sequencer: arbitration table, multi-cycle corner sequences and a randomized
// run compared cycle by cycle against a behavioural reference model.
module tb_clock_op_sequencer;

  localparam int D  = 4;
  localparam int TD = 10;
  localparam int HO = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_madd = 1'b0;
  logic       btn_sto0 = 1'b0;
  logic       btn_reset = 1'b0;
  logic       op_ack = 1'b0;
  logic       op_valid;
  logic [1:0] op_code;
  logic       sec_tick;
  logic       busy;

  int errors = 0;
  int checks = 0;

  clock_op_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .TICK_DIV       (TD),
    .HOLDOFF_CYCLES (HO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_madd  (btn_madd),
    .btn_sto0  (btn_sto0),
    .btn_reset (btn_reset),
    .op_ack    (op_ack),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .sec_tick  (sec_tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_madd = 1'b0; btn_sto0 = 1'b0; btn_reset = 1'b0; op_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [D+1:0] m_hist [3];
  logic [2:0]   m_lvl;
  logic [2:0]   m_rise;
  logic [2:0]   m_pend;
  logic         m_valid;
  logic [1:0]   m_code;
  int           m_hold;
  int           m_phase;

  function automatic logic [1:0] winner(input logic [2:0] p);
    if (p[2]) return 2'b11;
    if (p[1]) return 2'b01;
    if (p[0]) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    m_lvl = '0; m_rise = '0; m_pend = '0;
    m_valid = 1'b0; m_code = 2'b00; m_hold = 0; m_phase = 0;
  endtask

  function automatic logic [4:0] model_out(input logic ack);
    logic rs, tk, bz;
    rs = m_valid && ack && (m_code == 2'b01 || m_code == 2'b11);
    tk = (m_phase == TD - 1) && !rs;
    bz = (m_pend != 3'b000) || m_valid || (m_hold > 0);
    return {m_valid, m_code, tk, bz};
  endfunction

  task automatic model_step(input logic [2:0] b, input logic ack);
    logic [2:0] clr;
    logic [2:0] old_pend;
    logic [D-1:0] win;
    logic rs;
    clr = 3'b000;
    old_pend = m_pend;
    rs = m_valid && ack && (m_code == 2'b01 || m_code == 2'b11);
    if (m_valid && ack)
      clr = (m_code == 2'b11) ? 3'b111 : ((m_code == 2'b01) ? 3'b010 : 3'b001);
    m_pend = (old_pend & ~clr) | m_rise;
    // A button level is accepted once the last D synchronised samples all disagree with it.
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = {m_hist[i][D:0], b[i]};
      win = m_hist[i][D+1:2];
      m_rise[i] = 1'b0;
      if (m_lvl[i] == 1'b0 && win == {D{1'b1}}) begin
        m_lvl[i] = 1'b1;
        m_rise[i] = 1'b1;
      end else if (m_lvl[i] == 1'b1 && win == {D{1'b0}}) begin
        m_lvl[i] = 1'b0;
      end
    end
    if (m_valid) begin
      if (ack) begin
        m_valid = 1'b0;
        m_code = 2'b00;
        m_hold = HO;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (old_pend != 3'b000) begin
      m_valid = 1'b1;
      m_code = winner(old_pend);
    end
    m_phase = rs ? 0 : (m_phase + 1) % TD;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [2:0] press;   // {reset, sto0, madd}
    int         ops;
    logic [1:0] first;
    logic [1:0] second;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int ops;
    logic seen;
    logic stay;
    logic [1:0] codes[2];
    logic [2:0] b;
    int hold[3];

    vecs[0] = '{3'b001, 1, 2'b10, 2'b00};
    vecs[1] = '{3'b010, 1, 2'b01, 2'b00};
    vecs[2] = '{3'b100, 1, 2'b11, 2'b00};
    vecs[3] = '{3'b011, 2, 2'b01, 2'b10};
    vecs[4] = '{3'b111, 1, 2'b11, 2'b00};
    vecs[5] = '{3'b110, 1, 2'b11, 2'b00};
    vecs[6] = '{3'b101, 1, 2'b11, 2'b00};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", op_valid, 0);
    check("rst_code", op_code, 0);
    check("rst_tick", sec_tick, 0);
    check("rst_busy", busy, 0);

    // Single madd press: 7 cycles after the first edge that samples it
    do_reset();
    btn_madd = 1'b1;
    n = 0;
    while (op_valid !== 1'b1 && n < 30) begin cyc(); n++; end
    check("t1_latency", n, 8);
    check("t1_code", op_code, 2'b10);
    cyc(); op_ack = 1'b1;
    cyc(); op_ack = 1'b0;
    check("t1_drop", op_valid, 0);
    btn_madd = 1'b0;
    ops = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (op_valid) begin ops++; op_ack = 1'b1; end else op_ack = 1'b0;
    end
    op_ack = 1'b0;
    check("t1_extra_ops", ops, 0);
    check("t1_idle_busy", busy, 0);

    // Short glitches never qualify
    for (int len = 1; len <= 3; len++) begin
      do_reset();
      btn_madd = 1'b1;
      repeat (len) cyc();
      btn_madd = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
        cyc();
        if (op_valid || busy) seen = 1'b1;
      end
      check($sformatf("t2_glitch%0d", len), seen, 0);
    end

    // Arbitration table: simultaneous presses, immediate ack
    for (int v = 0; v < 7; v++) begin
      do_reset();
      {btn_reset, btn_sto0, btn_madd} = vecs[v].press;
      ops = 0;
      codes[0] = 2'b00; codes[1] = 2'b00;
      for (int i = 0; i < 60; i++) begin
        if (i == 10) {btn_reset, btn_sto0, btn_madd} = 3'b000;
        if (op_valid) begin
          if (ops < 2) codes[ops] = op_code;
          ops++;
          op_ack = 1'b1;
        end else begin
          op_ack = 1'b0;
        end
        cyc();
      end
      op_ack = 1'b0;
      check($sformatf("tab%0d_ops", v), ops, vecs[v].ops);
      check($sformatf("tab%0d_first", v), codes[0], vecs[v].first);
      check($sformatf("tab%0d_second", v), codes[1], vecs[v].second);
    end

    // Delayed ack with a higher-priority press meanwhile: no preemption
    do_reset();
    btn_madd = 1'b1;
    n = 0;
    while (op_valid !== 1'b1 && n < 30) begin cyc(); n++; end
    check("t4_code", op_code, 2'b10);
    stay = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) btn_madd = 1'b0;
      if (i == 3) btn_reset = 1'b1;
      if (i == 13) btn_reset = 1'b0;
      cyc();
      if (!(op_valid === 1'b1 && op_code === 2'b10)) stay = 1'b0;
    end
    check("t4_frozen", stay, 1);
    op_ack = 1'b1;
    cyc(); op_ack = 1'b0;
    check("t4_ack_drop", op_valid, 0);
    n = 0;
    while (op_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    check("t4_gap", n, 3);
    check("t4_code2", op_code, 2'b11);
    op_ack = 1'b1;
    cyc(); op_ack = 1'b0;
    ops = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (op_valid) begin ops++; op_ack = 1'b1; end else op_ack = 1'b0;
    end
    op_ack = 1'b0;
    check("t4_no_more", ops, 0);

    // Prescaler period and re-phasing on a sto0 ack at the terminal count
    do_reset();
    n = 0;
    while (sec_tick !== 1'b1 && n < 30) begin cyc(); n++; end
    check("t5_first", n, 9);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin cyc(); n++; end while (sec_tick !== 1'b1 && n < 30);
      check($sformatf("t5_period%0d", k), n, 10);
    end
    btn_sto0 = 1'b1;
    n = 0;
    while (op_valid !== 1'b1 && n < 30) begin
      cyc(); n++;
      if (n == 10) btn_sto0 = 1'b0;
    end
    btn_sto0 = 1'b0;
    check("t5_code", op_code, 2'b01);
    n = 0;
    while (sec_tick !== 1'b1 && n < 15) begin cyc(); n++; end
    check("t5_at_terminal", sec_tick, 1);
    op_ack = 1'b1;
    #1;
    check("t5_suppress", sec_tick, 0);
    cyc(); op_ack = 1'b0;
    check("t5_acked", op_valid, 0);
    n = 1;
    while (sec_tick !== 1'b1 && n < 30) begin cyc(); n++; end
    check("t5_retick", n, 10);

    // Asynchronous reset mid-handshake abandons the op
    do_reset();
    btn_madd = 1'b1;
    n = 0;
    while (op_valid !== 1'b1 && n < 30) begin cyc(); n++; end
    check("t6_valid", op_valid, 1);
    #2;
    rst = 1'b1;
    btn_madd = 1'b0;
    #1;
    check("t6_valid_clr", op_valid, 0);
    check("t6_code_clr", op_code, 0);
    check("t6_busy_clr", busy, 0);
    check("t6_tick_clr", sec_tick, 0);
    repeat (2) cyc();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (op_valid || busy) seen = 1'b1;
    end
    check("t6_no_replay", seen, 0);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    b = 3'b000;
    for (int i = 0; i < 3; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          b[i] = ~b[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                : int'($urandom_range(5, 40));
        end
        hold[i]--;
      end
      {btn_reset, btn_sto0, btn_madd} = b;
      op_ack = ($urandom_range(0, 2) == 0);
      #1;
      check($sformatf("rand_c%0d", c), {op_valid, op_code, sec_tick, busy}, model_out(op_ack));
      @(posedge clk);
      model_step(b, op_ack);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
